// File: rtl/sync_asym_fifo_lvl.sv
// sync_asym_fifo_lvl
//   Single-clock FIFO with independent write/read widths (either may be wider).
//   Storage is a register array of narrow (MIN_W) slots. The level is kept in
//   narrow words, and every flag is decoded from the registered level.
//
//   Build option: define SYNC_ASYM_FIFO_FWFT_EN for first-word-fall-through.
//   In that mode data_out shows the word at the read pointer combinationally,
//   and read_en acts as a pop acknowledge. With the macro undefined, data_out
//   is registered: it is valid one cycle after an accepted read and holds
//   until the next one.
//
//   Ports:
//     clk, rst      clock; asynchronous active-high reset
//     write_en      write request (refused while full)
//     data_in       W_DATA_W write word, earliest narrow word in the LSBs
//     full          fewer than W_RATIO free narrow slots
//     almost_full   level >= ALMOST_FULL_LVL
//     read_en       read request / pop (refused while empty)
//     data_out      R_DATA_W read word, oldest narrow word in the LSBs
//     empty         fewer than R_RATIO stored narrow slots
//     almost_empty  level <= ALMOST_EMPTY_LVL
//     level         occupancy in narrow words, 0..2**ADDR_W
module sync_asym_fifo_lvl #(
  parameter int W_DATA_W         = 32,
  parameter int R_DATA_W         = 8,
  parameter int ADDR_W           = 4,
  parameter int ALMOST_FULL_LVL  = 2**ADDR_W - 1,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_en,
  input  logic [W_DATA_W-1:0] data_in,
  output logic                full,
  output logic                almost_full,
  input  logic                read_en,
  output logic [R_DATA_W-1:0] data_out,
  output logic                empty,
  output logic                almost_empty,
  output logic [ADDR_W:0]     level
);

  localparam int MIN_W     = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int W_RATIO   = W_DATA_W / MIN_W;
  localparam int R_RATIO   = R_DATA_W / MIN_W;
  localparam int MAX_RATIO = (W_RATIO > R_RATIO) ? W_RATIO : R_RATIO;
  localparam int DEPTH     = 2**ADDR_W;
  localparam int LW        = ADDR_W + 1;

  // Elaboration-time legality of the width/depth combination.
  if ((W_DATA_W % MIN_W) != 0 || (R_DATA_W % MIN_W) != 0) begin : g_bad_ratio
    $fatal(1, "sync_asym_fifo_lvl: W_DATA_W and R_DATA_W must be integer multiples of each other");
  end
  if (DEPTH < MAX_RATIO) begin : g_bad_depth
    $fatal(1, "sync_asym_fifo_lvl: depth 2**ADDR_W smaller than the width ratio");
  end

  logic [MIN_W-1:0]    mem_q [DEPTH];
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                wr_int, rd_int;
  logic [R_DATA_W-1:0] rd_word;

  // Flags come from the pre-cycle level only. A simultaneous read and write
  // are therefore each judged on their own, and the level moves by the net.
  assign full         = level_q > LW'(DEPTH - W_RATIO);
  assign empty        = level_q < LW'(R_RATIO);
  assign almost_full  = int'(level_q) >= ALMOST_FULL_LVL;
  assign almost_empty = int'(level_q) <= ALMOST_EMPTY_LVL;
  assign level        = level_q;

  assign wr_int = write_en & ~full;
  assign rd_int = read_en & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q + (wr_int ? LW'(W_RATIO) : '0) - (rd_int ? LW'(R_RATIO) : '0);
    // Pointers wrap naturally at ADDR_W bits.
    if (wr_int) wptr_d = wptr_q + ADDR_W'(W_RATIO);
    if (rd_int) rptr_d = rptr_q + ADDR_W'(R_RATIO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Array is deliberately not reset; stale slots are unreachable because the
  // level gates every read.
  always_ff @(posedge clk) begin
    if (wr_int) begin
      for (int i = 0; i < W_RATIO; i++)
        mem_q[wptr_q + ADDR_W'(i)] <= data_in[i*MIN_W +: MIN_W];
    end
  end

  // Gather R_RATIO consecutive slots starting at the read pointer, with
  // wrap-around; the oldest slot lands in the LSBs.
  for (genvar j = 0; j < R_RATIO; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rptr_q + ADDR_W'(j);
    assign rd_word[j*MIN_W +: MIN_W] = mem_q[ra];
  end

`ifdef SYNC_ASYM_FIFO_FWFT_EN
  // Head word is always presented; read_en only pops it.
  assign data_out = rd_word;
`else
  logic [R_DATA_W-1:0] data_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data_out_q <= '0;
    else if (rd_int) data_out_q <= rd_word;
  end

  assign data_out = data_out_q;
`endif

endmodule
